// File: rtl/scan_addr_gen.sv
// Scan sequencer for a 3-to-8 active-low decoder.
// Walks the enabled channels one slot each, blanking before every drive.
module scan_addr_gen #(
  parameter int CLK_DIV   = 1000,
  parameter int BLANK_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] ch_mask,
  output logic       A2,
  output logic       A1,
  output logic       A0,
  output logic       E1_n,
  output logic       E2_n,
  output logic       E3,
  output logic [2:0] cur_ch,
  output logic       slot_start,
  output logic       frame_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BL_LT = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] DR_1ST = CW'(BLANK_CYC);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    addr_q, addr_d;
  logic [2:0]    out_q;
  logic          drive_q;
  logic          start_q;
  logic          done_q;
  logic [7:0]    above;
  logic          last_ch;
  logic          boundary;

  function automatic logic [2:0] lowest(input logic [7:0] m);
    lowest = '0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) lowest = i[2:0];
  endfunction

  always_comb begin
    above    = ch_mask & (8'hFE << addr_q);
    last_ch  = ~|above;
    boundary = (state_q == DRIVE) && (cnt_q == LAST);
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    addr_d   = addr_q;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (|ch_mask) begin
            state_d = BLANK;
            addr_d  = lowest(ch_mask);
          end
        end
        BLANK: begin
          if (cnt_q == BL_LT) state_d = DRIVE;
        end
        DRIVE: begin
          if (cnt_q == LAST) begin
            cnt_d = '0;
            if (|ch_mask) begin
              state_d = BLANK;
              addr_d  = last_ch ? lowest(ch_mask)
                                : lowest(above);
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Output stage trails the FSM by one cycle, so a new address
  // always lands in a cycle whose enables are already off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      drive_q <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      drive_q <= en && (state_q == DRIVE);
      start_q <= en && (state_q == DRIVE)
                    && (cnt_q == DR_1ST);
      done_q  <= en && boundary && last_ch;
      if (en) out_q <= addr_q;
    end
  end

  assign {A2, A1, A0} = out_q;
  assign cur_ch       = out_q;
  assign E3           = drive_q;
  assign E1_n         = ~drive_q;
  assign E2_n         = ~drive_q;
  assign slot_start   = start_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_scan_addr_gen.sv
// Bench for scan_addr_gen: directed scenarios plus random en/mask
// traffic, all checked against a slot-position reference model.
module tb_scan_addr_gen;

  localparam int CD = 10;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] ch_mask;
  logic       A2, A1, A0;
  logic       E1_n, E2_n, E3;
  logic [2:0] cur_ch;
  logic       slot_start, frame_done;

  scan_addr_gen #(
    .CLK_DIV  (CD),
    .BLANK_CYC(BC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .ch_mask   (ch_mask),
    .A2        (A2),
    .A1        (A1),
    .A0        (A0),
    .E1_n      (E1_n),
    .E2_n      (E2_n),
    .E3        (E3),
    .cur_ch    (cur_ch),
    .slot_start(slot_start),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  bit   m_run;
  int   m_pos;
  int   m_ch;
  int   e_cur;
  bit   e_e3, e_ss, e_fd;
  logic [2:0] prev_ch;
  int   starts_q[$];
  int   done_at[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int lowest(input logic [7:0] m);
    for (int i = 0; i < 8; i++)
      if (m[i]) return i;
    return 0;
  endfunction

  function automatic bit any_above(input logic [7:0] m,
                                   input int c);
    return (m >> (c + 1)) != 8'h00;
  endfunction

  function automatic int next_ch(input logic [7:0] m,
                                 input int c);
    for (int i = c + 1; i < 8; i++)
      if (m[i]) return i;
    return lowest(m);
  endfunction

  task automatic model_reset();
    m_run   = 1'b0;
    m_pos   = 0;
    m_ch    = 0;
    e_cur   = 0;
    prev_ch = 3'd0;
  endtask

  // One clock: predict from the pre-edge model, advance it, compare.
  task automatic step();
    @(posedge clk);
    e_e3 = en && m_run && (m_pos >= BC);
    e_ss = en && m_run && (m_pos == BC);
    e_fd = en && m_run && (m_pos == CD - 1)
              && !any_above(ch_mask, m_ch);
    if (en) e_cur = m_ch;
    if (!en) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      if (ch_mask != 8'h00) begin
        m_run = 1'b1;
        m_pos = 0;
        m_ch  = lowest(ch_mask);
      end
    end else if (m_pos == CD - 1) begin
      if (ch_mask != 8'h00) begin
        m_pos = 0;
        m_ch  = next_ch(ch_mask, m_ch);
      end else begin
        m_run = 1'b0;
      end
    end else begin
      m_pos++;
    end
    #1;
    cyc++;
    chk("e3", E3, e_e3);
    chk("e1n", E1_n, !e_e3);
    chk("e2n", E2_n, !e_e3);
    chk("slot_start", slot_start, e_ss);
    chk("frame_done", frame_done, e_fd);
    chk("cur_ch", cur_ch, e_cur);
    chk("addr", {A2, A1, A0}, e_cur);
    if (E3) chk("addr_hold", cur_ch, prev_ch);
    prev_ch = cur_ch;
    if (slot_start) starts_q.push_back(int'(cur_ch));
    if (frame_done) done_at.push_back(cyc);
    @(negedge clk);
  endtask

  task automatic measure_start(input int exp_ch);
    int first;
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (E3 && first == 0) begin
        first = k;
        chk("start_ch", cur_ch, exp_ch);
      end
    end
    chk("start_lat", first, 4);
  endtask

  task automatic wait_drive(input int c);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      step();
      if (E3 && cur_ch == c[2:0]) ok = 1'b1;
    end
    chk("find_drive", ok, 1'b1);
  endtask

  task automatic restart(input logic [7:0] m);
    en = 1'b0;
    repeat (2) step();
    ch_mask = m;
    en      = 1'b1;
    starts_q.delete();
    done_at.delete();
  endtask

  task automatic chk_seq(input string tag, input int exp[$]);
    chk({tag, "_n"}, starts_q.size() >= exp.size(), 1'b1);
    foreach (exp[i])
      if (i < starts_q.size())
        chk(tag, starts_q[i], exp[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    en      = 1'b1;
    ch_mask = 8'hFF;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_e3", E3, 1'b0);
    chk("rst_e1n", E1_n, 1'b1);
    chk("rst_e2n", E2_n, 1'b1);
    chk("rst_addr", {A2, A1, A0}, 3'd0);
    chk("rst_cur", cur_ch, 3'd0);
    chk("rst_ss", slot_start, 1'b0);
    chk("rst_fd", frame_done, 1'b0);

    // Full scan straight out of reset
    rst_n = 1'b1;
    measure_start(0);
    repeat (162) step();
    chk_seq("full_seq", '{0, 1, 2, 3, 4, 5, 6, 7, 0});
    chk("full_fd_n", done_at.size(), 2);
    if (done_at.size() == 2) begin
      chk("full_fd_at", done_at[0], 81);
      chk("full_fd_per", done_at[1] - done_at[0], 80);
    end

    // Sparse mask
    restart(8'b1010_0100);
    repeat (70) step();
    chk_seq("sparse_seq", '{2, 5, 7, 2});
    chk("sparse_fd_n", done_at.size(), 2);
    if (done_at.size() == 2)
      chk("sparse_fd_per", done_at[1] - done_at[0], 30);

    // Mask shrinks while channel 3 is driven
    restart(8'hFF);
    wait_drive(3);
    ch_mask = 8'h01;
    starts_q.delete();
    done_at.delete();
    repeat (40) step();
    chk_seq("mid_seq", '{0, 0, 0});
    chk("mid_fd_n", done_at.size() >= 3, 1'b1);
    if (done_at.size() >= 3) begin
      chk("mid_fd_per1", done_at[1] - done_at[0], 10);
      chk("mid_fd_per2", done_at[2] - done_at[1], 10);
    end

    // en drop during channel 4 drive
    restart(8'hFF);
    wait_drive(4);
    en = 1'b0;
    step();
    chk("drop_e3", E3, 1'b0);
    chk("drop_cur", cur_ch, 3'd4);
    starts_q.delete();
    done_at.delete();
    repeat (5) step();
    chk("drop_cur2", cur_ch, 3'd4);
    chk("drop_pulses", starts_q.size() + done_at.size(), 0);
    en = 1'b1;
    measure_start(0);

    // Empty mask holds IDLE, then a single high channel
    restart(8'h00);
    repeat (10) step();
    chk("empty_e3", E3, 1'b0);
    chk("empty_ss", starts_q.size(), 0);
    ch_mask = 8'h80;
    measure_start(7);

    // Asynchronous reset in the middle of a slot
    repeat (7) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_e3", E3, 1'b0);
    chk("arst_e1n", E1_n, 1'b1);
    chk("arst_cur", cur_ch, 3'd0);
    chk("arst_ss", slot_start, 1'b0);
    model_reset();
    @(negedge clk);
    ch_mask = 8'h30;
    rst_n   = 1'b1;
    measure_start(4);

    // Random en / mask traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 14) == 0)
        ch_mask = ($urandom_range(0, 5) == 0)
                  ? 8'h00 : 8'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
